// File: rtl/parity_tx_pkg.sv
// Shared types and constants for the parity serial transmitter.
//   tx_state_t     frame phase of the serializer FSM
//   TX_IDLE_LEVEL  level held on the serial line between frames
package parity_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity of one data word, built from xor gate primitives.
//   data  in   DATA_W  word to reduce
//   par   out  1       XOR reduction of data, inverted when ODD_PARITY != 0
module parity_calc
   import parity_tx_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int ODD_PARITY = 0
) (
   input  logic [DATA_W-1:0] data,
   output logic              par
);

   localparam logic ODD_BIT = (ODD_PARITY != 0);

   // w_chain[i] holds the XOR of data[0..i]
   logic [DATA_W-1:0] w_chain;

   assign w_chain[0] = data[0];

   for (genvar i = 1; i < DATA_W; i++) begin : g_xor
      xor u_xor (w_chain[i], w_chain[i-1], data[i]);
   end

   assign par = w_chain[DATA_W-1] ^ ODD_BIT;

endmodule

// File: rtl/parity_tx_serializer.sv
// Serial transmit stage: accepts a word on a valid/ready handshake and sends
// start bit, data bits LSB first, parity bit, stop bit on a registered line.
//   clk       in   1       single clock, rising edge
//   rst       in   1       asynchronous active-high reset
//   in_data   in   DATA_W  word to transmit, sampled on acceptance only
//   in_valid  in   1       source has a word
//   in_ready  out  1       high in IDLE only (registered)
//   tx        out  1       serial line, idle high (registered)
//   busy      out  1       frame in progress (registered)
//   par_out   out  1       parity of the most recently accepted word
//
// state  | meaning
// IDLE   | line high, ready for a word
// START  | start bit (0) for one bit period
// DATA   | data bit r_bit_idx from shift register bit 0
// PARITY | stored parity bit for one bit period
// STOP   | stop bit (1) for one bit period
module parity_tx_serializer
   import parity_tx_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int ODD_PARITY   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx,
   output logic              busy,
   output logic              par_out
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   tx_state_t         r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [IDX_W-1:0]  r_bit_idx;
   logic [DATA_W-1:0] r_shreg;
   logic              r_tx;
   logic              r_in_ready;
   logic              r_busy;
   logic              r_par_out;

   logic              w_par;
   logic              w_period_end;
   logic [DATA_W-1:0] w_shift_next;

   parity_calc #(
      .DATA_W     (DATA_W),
      .ODD_PARITY (ODD_PARITY)
   ) u_parity_calc (
      .data (in_data),
      .par  (w_par)
   );

   // Bit-period timer counts down from CLKS_PER_BIT-1; zero marks the last cycle.
   assign w_period_end = (r_cnt == '0);
   assign w_shift_next = r_shreg >> 1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_bit_idx  <= '0;
         r_shreg    <= '0;
         r_tx       <= TX_IDLE_LEVEL;
         r_in_ready <= 1'b1;
         r_busy     <= 1'b0;
         r_par_out  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_shreg    <= in_data;
                  r_par_out  <= w_par;
                  r_state    <= START;
                  r_cnt      <= CNT_LOAD;
                  r_bit_idx  <= '0;
                  r_tx       <= 1'b0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            START: begin
               if (w_period_end) begin
                  r_state <= DATA;
                  r_cnt   <= CNT_LOAD;
                  r_tx    <= r_shreg[0];
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            DATA: begin
               if (w_period_end) begin
                  r_cnt <= CNT_LOAD;
                  if (r_bit_idx == IDX_LAST) begin
                     r_state   <= PARITY;
                     r_bit_idx <= '0;
                     r_tx      <= r_par_out;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                     r_shreg   <= w_shift_next;
                     // next bit is visible on the line in the same cycle the shift lands
                     r_tx      <= w_shift_next[0];
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            PARITY: begin
               if (w_period_end) begin
                  r_state <= STOP;
                  r_cnt   <= CNT_LOAD;
                  r_tx    <= TX_IDLE_LEVEL;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            STOP: begin
               if (w_period_end) begin
                  r_state    <= IDLE;
                  r_tx       <= TX_IDLE_LEVEL;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_cnt      <= '0;
               r_tx       <= TX_IDLE_LEVEL;
               r_in_ready <= 1'b1;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign tx       = r_tx;
   assign in_ready = r_in_ready;
   assign busy     = r_busy;
   assign par_out  = r_par_out;

endmodule

// File: tb/tb_parity_tx_serializer.sv
module tb_parity_tx_serializer;

   localparam int W     = 8;
   localparam int C     = 4;
   localparam int FRAME = C * (W + 3);
   localparam int TCLK  = 10;

   logic         clk;
   logic         rst;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         ready_e, tx_e, busy_e, par_e;
   logic         ready_o, tx_o, busy_o, par_o;

   int checks   = 0;
   int failures = 0;

   parity_tx_serializer #(.DATA_W(W), .CLKS_PER_BIT(C), .ODD_PARITY(0)) dut_even (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (ready_e),
      .tx       (tx_e),
      .busy     (busy_e),
      .par_out  (par_e)
   );

   parity_tx_serializer #(.DATA_W(W), .CLKS_PER_BIT(C), .ODD_PARITY(1)) dut_odd (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (ready_o),
      .tx       (tx_o),
      .busy     (busy_o),
      .par_out  (par_o)
   );

   initial clk = 1'b0;
   always #(TCLK/2) clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
      end
   endtask

   // Reference parity: count ones, even count means even parity bit 0.
   function automatic logic model_par(input logic [W-1:0] d, input bit odd);
      int ones;
      ones = 0;
      for (int i = 0; i < W; i++) ones += int'(d[i]);
      return logic'((ones % 2) == 1) ^ logic'(odd);
   endfunction

   // Expected line level during frame bit slot j (0 = start ... W+2 = stop).
   function automatic logic model_bit(input logic [W-1:0] d, input bit odd, input int j);
      if (j == 0) return 1'b0;
      if (j <= W) return d[j-1];
      if (j == W + 1) return model_par(d, odd);
      return 1'b1;
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_tx_e"}, tx_e, 1'b1);
      chk({tag, "_rdy_e"}, ready_e, 1'b1);
      chk({tag, "_busy_e"}, busy_e, 1'b0);
      chk({tag, "_tx_o"}, tx_o, 1'b1);
      chk({tag, "_rdy_o"}, ready_o, 1'b1);
      chk({tag, "_busy_o"}, busy_o, 1'b0);
   endtask

   // Called at a negedge. Offers d, waits (bounded) for acceptance, then checks
   // every cycle of the frame against the model. abort_k > 0 asserts rst at that cycle.
   task automatic send_word(input logic [W-1:0] d, input bit keep_valid,
                            input bit glitch, input int abort_k, output time t_acc);
      int n;
      in_data  = d;
      in_valid = 1'b1;
      n = 0;
      while (ready_e !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", ready_e, 1'b1);
      @(posedge clk);
      t_acc = $time;
      @(negedge clk);
      for (int k = 1; k <= FRAME; k++) begin
         if (k == 1) begin
            if (!keep_valid) in_valid = 1'b0;
            if (glitch) in_data = 8'h3C;
            chk("par_out_e", par_e, model_par(d, 1'b0));
            chk("par_out_o", par_o, model_par(d, 1'b1));
         end
         if (k == abort_k) begin
            rst = 1'b1;
            #1;
            chk_idle("abort");
            return;
         end
         chk($sformatf("tx_e_k%0d", k), tx_e, model_bit(d, 1'b0, (k - 1) / C));
         chk($sformatf("tx_o_k%0d", k), tx_o, model_bit(d, 1'b1, (k - 1) / C));
         chk("busy_frame", busy_e, 1'b1);
         chk("rdy_frame", ready_e, 1'b0);
         chk("busy_frame_o", busy_o, 1'b1);
         @(negedge clk);
      end
      chk_idle("post_frame");
   endtask

   initial begin
      time t1, t2, tdummy;
      logic [W-1:0] rd;
      int gap;

      // Reset then idle
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(negedge clk);
      chk_idle("in_reset");
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk_idle("idle");
         chk("idle_par_e", par_e, 1'b0);
         chk("idle_par_o", par_o, 1'b0);
      end

      // Single frame A5, then 07 (covers both parities via the two instances)
      send_word(8'hA5, 1'b0, 1'b0, 0, tdummy);
      chk("a5_par_even", par_e, 1'b0);
      repeat (2) @(negedge clk);
      send_word(8'h07, 1'b0, 1'b0, 0, tdummy);
      chk("07_par_even", par_e, 1'b1);
      chk("07_par_odd", par_o, 1'b0);
      repeat (3) @(negedge clk);

      // Back-to-back with in_valid held high
      send_word(8'h00, 1'b1, 1'b0, 0, t1);
      send_word(8'hFF, 1'b0, 1'b0, 0, t2);
      checks++;
      assert ((t2 - t1) === time'((FRAME + 1) * TCLK)) else begin
         failures++;
         $error("FAIL b2b_spacing observed=%0t expected=%0d", t2 - t1, (FRAME + 1) * TCLK);
      end
      @(negedge clk);

      // in_data glitch after acceptance
      send_word(8'h81, 1'b0, 1'b1, 0, tdummy);
      @(negedge clk);

      // Reset during data bit 3 (cycles 17..20)
      send_word(8'hA5, 1'b0, 1'b0, 18, tdummy);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_idle("after_abort");
      send_word(8'h01, 1'b0, 1'b0, 0, tdummy);
      chk("01_par_even", par_e, 1'b1);

      // Random words with random idle gaps
      for (int r = 0; r < 8; r++) begin
         rd  = W'($urandom);
         gap = int'($urandom_range(0, 3));
         repeat (gap) begin
            @(negedge clk);
            chk_idle("rand_gap");
         end
         send_word(rd, 1'b0, 1'b0, 0, tdummy);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
